// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - greedy five-denomination change payout sequencer
//
// Purpose:
//   Accepts a change amount from the transaction FSM and pays it out through
//   a coin/note hopper, largest denomination first, one unit per req/ack
//   handshake. Empty denominations are skipped; whatever cannot be paid is
//   reported as shortfall. An unanswered request times out and ends the
//   transaction with err=1.
//
// Ports:
//   sys_clk        system clock, rising edge
//   sys_rst_n      synchronous reset, active-high despite the name
//   start          one-cycle pulse, latches change_amount (ignored unless idle)
//   change_amount  amount to pay, unsigned yuan
//   abort          stop payout after the unit in flight
//   hopper_empty   per-denomination empty flags {50,20,10,5,1}
//   dispense_ack   hopper acknowledge level, high = unit delivered
//   dispense_req   one-hot request, same bit order as hopper_empty
//   busy           transaction in progress
//   done           one-cycle end-of-transaction pulse
//   err            request timed out (valid with done)
//   remaining      amount still owed, live
//   shortfall      unpaid amount at done, held until next start
//   units_out      units dispensed this transaction, saturating

module change_dispense_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic       abort,
  input  logic [4:0] hopper_empty,
  input  logic       dispense_ack,
  output logic [4:0] dispense_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] remaining,
  output logic [7:0] shortfall,
  output logic [7:0] units_out
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    WAIT_LOW,
    FINISH
  } state_t;

  state_t        state;
  logic [7:0]    cur_val;     // value of the denomination currently requested
  logic [TW-1:0] timer;       // cycles the current request has waited
  logic          abort_seen;  // abort observed since the last SELECT

  logic [4:0]    sel_oh;
  logic [7:0]    sel_val;

  // Greedy pick: largest stocked denomination not exceeding what is owed.
  // sel_oh stays zero when nothing qualifies (including remaining == 0).
  always_comb begin
    sel_oh  = 5'b00000;
    sel_val = 8'd0;
    if (!hopper_empty[4] && remaining >= 8'd50) begin
      sel_oh  = 5'b10000;
      sel_val = 8'd50;
    end else if (!hopper_empty[3] && remaining >= 8'd20) begin
      sel_oh  = 5'b01000;
      sel_val = 8'd20;
    end else if (!hopper_empty[2] && remaining >= 8'd10) begin
      sel_oh  = 5'b00100;
      sel_val = 8'd10;
    end else if (!hopper_empty[1] && remaining >= 8'd5) begin
      sel_oh  = 5'b00010;
      sel_val = 8'd5;
    end else if (!hopper_empty[0] && remaining >= 8'd1) begin
      sel_oh  = 5'b00001;
      sel_val = 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state        <= IDLE;
      dispense_req <= 5'b00000;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      remaining    <= 8'd0;
      shortfall    <= 8'd0;
      units_out    <= 8'd0;
      cur_val      <= 8'd0;
      timer        <= '0;
      abort_seen   <= 1'b0;
    end else begin
      done <= 1'b0;

      // Sticky abort; the state handling below may clear it again.
      if (busy && abort) begin
        abort_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= change_amount;
            units_out  <= 8'd0;
            shortfall  <= 8'd0;
            err        <= 1'b0;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end

        SELECT: begin
          abort_seen <= 1'b0;
          // remaining == 0 also lands here with sel_oh == 0, giving shortfall 0.
          if (abort || abort_seen || (sel_oh == 5'b00000)) begin
            shortfall <= remaining;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= FINISH;
          end else begin
            dispense_req <= sel_oh;
            cur_val      <= sel_val;
            timer        <= '0;
            state        <= REQ;
          end
        end

        REQ: begin
          // Ack is checked first so an ack on the expiry cycle still counts.
          if (dispense_ack) begin
            remaining    <= remaining - cur_val;
            if (units_out != 8'hFF) begin
              units_out <= units_out + 8'd1;
            end
            dispense_req <= 5'b00000;
            state        <= WAIT_LOW;
          end else if (timer == TIMER_LAST) begin
            dispense_req <= 5'b00000;
            err          <= 1'b1;
            shortfall    <= remaining;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WAIT_LOW: begin
          if (!dispense_ack) begin
            if (abort || abort_seen) begin
              shortfall <= remaining;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= FINISH;
            end else begin
              state <= SELECT;
            end
          end
        end

        FINISH: begin
          abort_seen <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - scoreboard bench for change_dispense_ctrl

module tb_change_dispense_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic [7:0] change_amount;
  logic       abort;
  logic [4:0] hopper_empty;
  logic       dispense_ack;
  logic [4:0] dispense_req;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] remaining;
  logic [7:0] shortfall;
  logic [7:0] units_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         done_cyc;
  bit         done_seen;
  int         max_req_hi;
  int         max_rem;

  always #5 sys_clk = ~sys_clk;

  change_dispense_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .start         (start),
    .change_amount (change_amount),
    .abort         (abort),
    .hopper_empty  (hopper_empty),
    .dispense_ack  (dispense_ack),
    .dispense_req  (dispense_req),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .remaining     (remaining),
    .shortfall     (shortfall),
    .units_out     (units_out)
  );

  // Drives a start pulse and records the requests the model predicts.
  task automatic do_start(input logic [7:0] amt, input logic [4:0] empty);
    @(negedge sys_clk);
    hopper_empty  = empty;
    change_amount = amt;
    start         = 1'b1;
  endtask

  // Hopper model: answers each request ack_delay cycles after it appears and
  // records the request sequence plus timing observations until done.
  task automatic run_payout(input int ack_delay, input bit never_ack,
                            input bit abort_on_ack, input int restart_at);
    int cnt = 0;
    int hi  = 0;
    int cyc = 0;
    bit abort_sent = 0;
    logic [4:0] prev = 5'b0;
    obs_q.delete();
    done_seen  = 0;
    done_cyc   = 0;
    max_req_hi = 0;
    max_rem    = 0;
    while (!done_seen && cyc < 2000) begin
      @(negedge sys_clk);
      cyc++;
      if (cyc == restart_at) begin
        start         = 1'b1;
        change_amount = 8'd99;
      end else begin
        start = 1'b0;
      end
      if (int'(remaining) > max_rem) max_rem = int'(remaining);
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      if (dispense_req != 5'b0) begin
        if (prev == 5'b0) begin
          obs_q.push_back(dispense_req);
          cnt = 0;
        end
        hi++;
        cnt++;
        if (hi > max_req_hi) max_req_hi = hi;
        if (!never_ack && cnt > ack_delay) begin
          dispense_ack = 1'b1;
          if (abort_on_ack && !abort_sent) begin
            abort      = 1'b1;
            abort_sent = 1;
          end
        end
      end else begin
        hi           = 0;
        dispense_ack = 1'b0;
        abort        = 1'b0;
      end
      prev = dispense_req;
    end
    start        = 1'b0;
    dispense_ack = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({dispense_req, busy, done, err} !== 8'd0)
      $display("FAIL reset_ctrl: observed %b expected 00000000", {dispense_req, busy, done, err});
    else n_pass++;
    n_checks++;
    if ({remaining, shortfall, units_out} !== 24'd0)
      $display("FAIL reset_counts: observed %h expected 000000", {remaining, shortfall, units_out});
    else n_pass++;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_greedy_86;
    logic [4:0] e, o;
    exp_q = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    do_start(8'd86, 5'b00000);
    run_payout(3, 0, 0, 0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL g86_nreq: observed %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      n_checks++;
      if (o !== e) $display("FAIL g86_req: observed %b expected %b", o, e);
      else n_pass++;
    end
    n_checks++;
    if (remaining !== 8'd0) $display("FAIL g86_remaining: observed %0d expected 0", remaining);
    else n_pass++;
    n_checks++;
    if (units_out !== 8'd5) $display("FAIL g86_units: observed %0d expected 5", units_out);
    else n_pass++;
    n_checks++;
    if ({err, shortfall} !== 9'd0) $display("FAIL g86_err_short: observed %0d/%0d expected 0/0", err, shortfall);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL g86_busy_at_done: observed %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_ignore_restart_40;
    logic [4:0] e, o;
    exp_q = '{5'b01000, 5'b01000};
    do_start(8'd40, 5'b00000);
    run_payout(3, 0, 0, 5);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL r40_nreq: observed %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      n_checks++;
      if (o !== e) $display("FAIL r40_req: observed %b expected %b", o, e);
      else n_pass++;
    end
    n_checks++;
    if (max_rem !== 40) $display("FAIL r40_max_remaining: observed %0d expected 40", max_rem);
    else n_pass++;
    n_checks++;
    if (units_out !== 8'd2) $display("FAIL r40_units: observed %0d expected 2", units_out);
    else n_pass++;
  endtask

  task automatic test_skip_empty_37;
    logic [4:0] e, o;
    exp_q = '{5'b01000, 5'b00100};
    repeat (7) exp_q.push_back(5'b00001);
    do_start(8'd37, 5'b00010);
    run_payout(2, 0, 0, 0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL s37_nreq: observed %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      n_checks++;
      if (o !== e) $display("FAIL s37_req: observed %b expected %b", o, e);
      else n_pass++;
    end
    n_checks++;
    if (units_out !== 8'd9) $display("FAIL s37_units: observed %0d expected 9", units_out);
    else n_pass++;
    n_checks++;
    if (shortfall !== 8'd0) $display("FAIL s37_shortfall: observed %0d expected 0", shortfall);
    else n_pass++;
  endtask

  task automatic test_no_stock_8;
    do_start(8'd8, 5'b00011);
    run_payout(1, 0, 0, 0);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL n8_nreq: observed %0d expected 0", obs_q.size());
    else n_pass++;
    n_checks++;
    if (done_cyc !== 2) $display("FAIL n8_done_latency: observed %0d expected 2", done_cyc);
    else n_pass++;
    n_checks++;
    if (shortfall !== 8'd8) $display("FAIL n8_shortfall: observed %0d expected 8", shortfall);
    else n_pass++;
  endtask

  task automatic test_timeout_55;
    do_start(8'd55, 5'b00000);
    run_payout(0, 1, 0, 0);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== 5'b10000)
      $display("FAIL t55_req: observed %0d reqs expected 1 of 10000", obs_q.size());
    else n_pass++;
    n_checks++;
    if (max_req_hi !== 16) $display("FAIL t55_req_cycles: observed %0d expected 16", max_req_hi);
    else n_pass++;
    n_checks++;
    if (done_cyc !== 18) $display("FAIL t55_done_latency: observed %0d expected 18", done_cyc);
    else n_pass++;
    n_checks++;
    if (err !== 1'b1) $display("FAIL t55_err: observed %b expected 1", err);
    else n_pass++;
    n_checks++;
    if (shortfall !== 8'd55) $display("FAIL t55_shortfall: observed %0d expected 55", shortfall);
    else n_pass++;
  endtask

  task automatic test_ack_at_timeout;
    logic [4:0] e, o;
    exp_q = '{5'b10000, 5'b00010};
    do_start(8'd55, 5'b00000);
    run_payout(15, 0, 0, 0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL at_nreq: observed %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      n_checks++;
      if (o !== e) $display("FAIL at_req: observed %b expected %b", o, e);
      else n_pass++;
    end
    n_checks++;
    if (err !== 1'b0) $display("FAIL at_err: observed %b expected 0", err);
    else n_pass++;
    n_checks++;
    if (units_out !== 8'd2) $display("FAIL at_units: observed %0d expected 2", units_out);
    else n_pass++;
  endtask

  task automatic test_abort_70;
    exp_q = '{5'b10000};
    do_start(8'd70, 5'b00000);
    run_payout(3, 0, 1, 0);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL a70_req: observed %0d reqs expected 1 of 10000", obs_q.size());
    else n_pass++;
    n_checks++;
    if (shortfall !== 8'd20) $display("FAIL a70_shortfall: observed %0d expected 20", shortfall);
    else n_pass++;
    n_checks++;
    if (units_out !== 8'd1) $display("FAIL a70_units: observed %0d expected 1", units_out);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL a70_err: observed %b expected 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_req;
    bit found = 0;
    int dones = 0;
    do_start(8'd70, 5'b00000);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sys_clk);
      start = 1'b0;
      if (dispense_req != 5'b0) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL rm_req_seen: observed 0 expected 1");
    else n_pass++;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if ({dispense_req, busy, done, err, remaining, shortfall, units_out} !== 32'd0)
      $display("FAIL rm_outputs: observed %h expected 0",
               {dispense_req, busy, done, err, remaining, shortfall, units_out});
    else n_pass++;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL rm_no_done: observed %0d expected 0", dones);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    sys_rst_n     = 1'b1;
    start         = 1'b0;
    change_amount = 8'd0;
    abort         = 1'b0;
    hopper_empty  = 5'b00000;
    dispense_ack  = 1'b0;
    test_reset();
    test_greedy_86();
    test_ignore_restart_40();
    test_skip_empty_37();
    test_no_stock_8();
    test_timeout_55();
    test_ack_at_timeout();
    test_abort_70();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
